// File: rtl/psram_arbiter.sv
// psram_arbiter: two-port arbiter sharing one psram controller, port 0 (video) has priority.
// Define PSRAM_ARB_STARVE_EN to force a port-1 grant after STARVE_LIMIT consecutive port-0 wins.
module psram_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_p0_req,
    input  logic        i_p0_we,
    input  logic [23:0] i_p0_addr,
    input  logic [15:0] i_p0_din,
    output logic        o_p0_ack,
    output logic        o_p0_done,
    output logic [15:0] o_p0_dout,
    input  logic        i_p1_req,
    input  logic        i_p1_we,
    input  logic [23:0] i_p1_addr,
    input  logic [15:0] i_p1_din,
    output logic        o_p1_ack,
    output logic        o_p1_done,
    output logic [15:0] o_p1_dout,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [23:0] o_mem_addr,
    output logic [15:0] o_mem_din,
    input  logic        i_mem_busy,
    input  logic        i_mem_done,
    input  logic [15:0] i_mem_dout,
    output logic [1:0]  o_grant
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic        any_req_s;
    logic        pick_p1_s;

    logic        p0_ack_r, p1_ack_r, p0_done_r, p1_done_r;
    logic [15:0] p0_dout_r, p1_dout_r;
    logic        stb_r, we_r;
    logic [23:0] addr_r;
    logic [15:0] din_r;
    logic [1:0]  grant_r;

    logic        p0_ack_nxt_s, p1_ack_nxt_s, p0_done_nxt_s, p1_done_nxt_s;
    logic [15:0] p0_dout_nxt_s, p1_dout_nxt_s;
    logic        stb_nxt_s, we_nxt_s;
    logic [23:0] addr_nxt_s;
    logic [15:0] din_nxt_s;
    logic [1:0]  grant_nxt_s;

    assign any_req_s = i_p0_req | i_p1_req;

`ifdef PSRAM_ARB_STARVE_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    logic [7:0] starve_cnt_r;

    assign pick_p1_s = i_p1_req & (~i_p0_req | (starve_cnt_r == LIMIT));

    // Count port-0 wins taken while port 1 was waiting; any other grant restarts the count.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            starve_cnt_r <= 8'd0;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            if (pick_p1_s || !i_p1_req) begin
                starve_cnt_r <= 8'd0;
            end else begin
                starve_cnt_r <= starve_cnt_r + 8'd1;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign pick_p1_s = i_p1_req & ~i_p0_req;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a done seen while still issuing short-circuits straight to idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_nxt_s = ST_ISSUE;
                else           state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (i_mem_done)      state_nxt_s = ST_IDLE;
                else if (i_mem_busy) state_nxt_s = ST_WAIT;
                else                 state_nxt_s = ST_ISSUE;
            end
            ST_WAIT: begin
                if (i_mem_done) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_WAIT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        p0_ack_nxt_s  = 1'b0;
        p1_ack_nxt_s  = 1'b0;
        p0_done_nxt_s = 1'b0;
        p1_done_nxt_s = 1'b0;
        p0_dout_nxt_s = p0_dout_r;
        p1_dout_nxt_s = p1_dout_r;
        stb_nxt_s     = stb_r;
        we_nxt_s      = we_r;
        addr_nxt_s    = addr_r;
        din_nxt_s     = din_r;
        grant_nxt_s   = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    stb_nxt_s = 1'b1;
                    if (pick_p1_s) begin
                        grant_nxt_s  = 2'b10;
                        p1_ack_nxt_s = 1'b1;
                        we_nxt_s     = i_p1_we;
                        addr_nxt_s   = i_p1_addr;
                        din_nxt_s    = i_p1_din;
                    end else begin
                        grant_nxt_s  = 2'b01;
                        p0_ack_nxt_s = 1'b1;
                        we_nxt_s     = i_p0_we;
                        addr_nxt_s   = i_p0_addr;
                        din_nxt_s    = i_p0_din;
                    end
                end else begin
                    stb_nxt_s   = 1'b0;
                    grant_nxt_s = 2'b00;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (i_mem_done) begin
                    stb_nxt_s   = 1'b0;
                    we_nxt_s    = 1'b0;
                    grant_nxt_s = 2'b00;
                    if (grant_r[1]) begin
                        p1_done_nxt_s = 1'b1;
                        p1_dout_nxt_s = i_mem_dout;
                    end else begin
                        p0_done_nxt_s = 1'b1;
                        p0_dout_nxt_s = i_mem_dout;
                    end
                end else if (i_mem_busy) begin
                    stb_nxt_s = 1'b0;
                end else begin
                    stb_nxt_s = stb_r;
                end
            end
            default: begin
                stb_nxt_s   = 1'b0;
                grant_nxt_s = 2'b00;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            p0_ack_r  <= 1'b0;
            p1_ack_r  <= 1'b0;
            p0_done_r <= 1'b0;
            p1_done_r <= 1'b0;
            p0_dout_r <= 16'h0000;
            p1_dout_r <= 16'h0000;
            stb_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= 24'h000000;
            din_r     <= 16'h0000;
            grant_r   <= 2'b00;
        end else begin
            p0_ack_r  <= p0_ack_nxt_s;
            p1_ack_r  <= p1_ack_nxt_s;
            p0_done_r <= p0_done_nxt_s;
            p1_done_r <= p1_done_nxt_s;
            p0_dout_r <= p0_dout_nxt_s;
            p1_dout_r <= p1_dout_nxt_s;
            stb_r     <= stb_nxt_s;
            we_r      <= we_nxt_s;
            addr_r    <= addr_nxt_s;
            din_r     <= din_nxt_s;
            grant_r   <= grant_nxt_s;
        end
    end

    assign o_p0_ack   = p0_ack_r;
    assign o_p1_ack   = p1_ack_r;
    assign o_p0_done  = p0_done_r;
    assign o_p1_done  = p1_done_r;
    assign o_p0_dout  = p0_dout_r;
    assign o_p1_dout  = p1_dout_r;
    assign o_mem_stb  = stb_r;
    assign o_mem_we   = we_r;
    assign o_mem_addr = addr_r;
    assign o_mem_din  = din_r;
    assign o_grant    = grant_r;

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed scenarios plus random traffic against a memory-level reference.
// Expected grant order follows PSRAM_ARB_STARVE_EN with STARVE_LIMIT = 3.
module tb_psram_arbiter;
    logic        clk;
    logic        i_rstn;
    logic        i_p0_req, i_p0_we, i_p1_req, i_p1_we;
    logic [23:0] i_p0_addr, i_p1_addr;
    logic [15:0] i_p0_din, i_p1_din;
    logic        o_p0_ack, o_p0_done, o_p1_ack, o_p1_done;
    logic [15:0] o_p0_dout, o_p1_dout;
    logic        o_mem_stb, o_mem_we;
    logic [23:0] o_mem_addr;
    logic [15:0] o_mem_din;
    logic        i_mem_busy, i_mem_done;
    logic [15:0] i_mem_dout;
    logic [1:0]  o_grant;

    psram_arbiter #(.STARVE_LIMIT(3)) dut (
        .i_clk(clk), .i_rstn(i_rstn),
        .i_p0_req(i_p0_req), .i_p0_we(i_p0_we), .i_p0_addr(i_p0_addr), .i_p0_din(i_p0_din),
        .o_p0_ack(o_p0_ack), .o_p0_done(o_p0_done), .o_p0_dout(o_p0_dout),
        .i_p1_req(i_p1_req), .i_p1_we(i_p1_we), .i_p1_addr(i_p1_addr), .i_p1_din(i_p1_din),
        .o_p1_ack(o_p1_ack), .o_p1_done(o_p1_done), .o_p1_dout(o_p1_dout),
        .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
        .i_mem_busy(i_mem_busy), .i_mem_done(i_mem_done), .i_mem_dout(i_mem_dout),
        .o_grant(o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // observation log
    int n_ack0, n_ack1, ack0_cyc, ack1_cyc, n_done0, n_done1, done0_cyc, done1_cyc, n_g, n_stb;
    logic [15:0] dout0_v, dout1_v;
    logic [1:0]  grant_or;
    logic        stb_at_done;
    int          order_q[$];
    bit          hold0, hold1;

    // controller/device model
    int          bd, dd, mcnt;
    bit          nob, act;
    logic        dev_we;
    logic [23:0] dev_addr;
    logic [15:0] dev_din;
    logic [15:0] mem_dev [logic [23:0]];
    logic [15:0] ref_mem [logic [23:0]];

    function automatic logic [15:0] dflt(input logic [23:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] dev_rd(input logic [23:0] a);
        return mem_dev.exists(a) ? mem_dev[a] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [79:0] outs();
        return {o_p0_ack, o_p1_ack, o_p0_done, o_p1_done, o_p0_dout, o_p1_dout,
                o_mem_stb, o_mem_we, o_mem_addr, o_mem_din, o_grant};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        n_ack0 = 0; n_ack1 = 0; ack0_cyc = 0; ack1_cyc = 0;
        n_done0 = 0; n_done1 = 0; done0_cyc = 0; done1_cyc = 0;
        n_g = 0; n_stb = 0; grant_or = 2'b00; stb_at_done = 1'b0;
        order_q.delete();
    endtask

    // One cycle: sample outputs at the falling edge, then advance the controller model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (o_p0_ack === 1'b1) begin
            n_ack0++; ack0_cyc = cyc; order_q.push_back(0);
            if (!hold0) i_p0_req = 1'b0;
        end
        if (o_p1_ack === 1'b1) begin
            n_ack1++; ack1_cyc = cyc; order_q.push_back(1);
            if (!hold1) i_p1_req = 1'b0;
        end
        if (o_p0_done === 1'b1) begin
            n_done0++; done0_cyc = cyc; dout0_v = o_p0_dout; stb_at_done = o_mem_stb;
        end
        if (o_p1_done === 1'b1) begin
            n_done1++; done1_cyc = cyc; dout1_v = o_p1_dout; stb_at_done = o_mem_stb;
        end
        grant_or = grant_or | o_grant;
        if (o_grant !== 2'b00) n_g++;
        if (o_mem_stb === 1'b1) n_stb++;
        if (!i_rstn) begin
            act = 1'b0; i_mem_busy = 1'b0; i_mem_done = 1'b0;
        end else if (i_mem_done) begin
            i_mem_done = 1'b0; act = 1'b0;
        end else if (act) begin
            mcnt++;
            if (mcnt == bd + dd) begin
                i_mem_busy = 1'b0;
                i_mem_done = 1'b1;
                if (dev_we) mem_dev[dev_addr] = dev_din;
                i_mem_dout = dev_we ? 16'hDEAD : dev_rd(dev_addr);
            end else if (mcnt >= bd && !nob) begin
                i_mem_busy = 1'b1;
            end
        end else if (o_mem_stb === 1'b1) begin
            act = 1'b1; mcnt = 0;
            dev_we = o_mem_we; dev_addr = o_mem_addr; dev_din = o_mem_din;
        end
    endtask

    task automatic run_until(input int target, input int maxc);
        int k;
        k = 0;
        while ((n_done0 + n_done1) < target && k < maxc) begin
            tick();
            k++;
        end
        check("timeout", 80'((n_done0 + n_done1) >= target), 80'd1);
    endtask

    bit          r0, r1, w0, w1;
    logic [23:0] a0, a1;
    logic [15:0] d0, d1, e0, e1;
    int          got, exp_port, scnt;

    initial begin
        i_rstn = 1'b0;
        i_p0_req = 1'b0; i_p0_we = 1'b0; i_p0_addr = 24'h0; i_p0_din = 16'h0;
        i_p1_req = 1'b0; i_p1_we = 1'b0; i_p1_addr = 24'h0; i_p1_din = 16'h0;
        i_mem_busy = 1'b0; i_mem_done = 1'b0; i_mem_dout = 16'h0;
        hold0 = 1'b0; hold1 = 1'b0; act = 1'b0; mcnt = 0; bd = 2; dd = 5; nob = 1'b0;
        dev_we = 1'b0; dev_addr = 24'h0; dev_din = 16'h0;
        mem_dev[24'h000123] = 16'h8765;
        ref_mem[24'h000123] = 16'h8765;
        clear_log();

        // reset, with a port-0 write asserted in the middle of it
        tick();
        i_p0_req = 1'b1; i_p0_we = 1'b1; i_p0_addr = 24'h000005; i_p0_din = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs", outs(), 80'd0);
        end
        check("rst_no_ack", 80'(n_ack0), 80'd0);
        i_p0_req = 1'b0;
        tick();
        i_rstn = 1'b1;
        tick(); tick();
        check("idle_outputs", outs(), 80'd0);
        check("idle_no_ack", 80'(n_ack0 + n_ack1), 80'd0);

        // single read on port 1
        clear_log(); bd = 2; dd = 5; nob = 1'b0;
        i_p1_req = 1'b1; i_p1_we = 1'b0; i_p1_addr = 24'h000123;
        run_until(1, 40);
        tick(); tick();
        check("p1_done_cnt", 80'(n_done1), 80'd1);
        check("p1_dout", 80'(dout1_v), 80'h8765);
        check("p0_no_done", 80'(n_done0), 80'd0);
        check("p1_grant_val", 80'(grant_or), 80'(2'b10));
        check("p1_grant_span", 80'(n_g), 80'(done1_cyc - ack1_cyc));
        check("p1_latency", 80'(done1_cyc - ack1_cyc), 80'(bd + dd + 1));
        check("p1_stb_len", 80'(n_stb), 80'(bd + 1));

        // simultaneous requests: port 0 write then port 1 read of the same word
        clear_log(); bd = 2; dd = 3;
        i_p0_req = 1'b1; i_p0_we = 1'b1; i_p0_addr = 24'h000010; i_p0_din = 16'hABCD;
        i_p1_req = 1'b1; i_p1_we = 1'b0; i_p1_addr = 24'h000010;
        ref_mem[24'h000010] = 16'hABCD;
        run_until(2, 80);
        tick(); tick();
        check("sim_p0_first", 80'(ack0_cyc < ack1_cyc), 80'd1);
        check("sim_b2b_ack", 80'(ack1_cyc), 80'(done0_cyc + 1));
        check("sim_done_cnt", 80'({n_done0[3:0], n_done1[3:0]}), 80'h11);
        check("sim_p1_dout", 80'(dout1_v), 80'(ref_rd(24'h000010)));

        // done without busy while still issuing
        clear_log(); bd = 1; dd = 2; nob = 1'b1;
        i_p0_req = 1'b1; i_p0_we = 1'b0; i_p0_addr = 24'h000010;
        run_until(1, 40);
        tick();
        check("issue_done_cnt", 80'(n_done0), 80'd1);
        check("issue_dout", 80'(dout0_v), 80'hABCD);
        check("issue_stb_at_done", 80'(stb_at_done), 80'd0);
        check("issue_stb_len", 80'(n_stb), 80'(done0_cyc - ack0_cyc));
        check("issue_stb_after", 80'(o_mem_stb), 80'd0);
        nob = 1'b0;

        // both ports requesting continuously
        clear_log(); bd = 1; dd = 1; hold0 = 1'b1; hold1 = 1'b1;
        i_p0_req = 1'b1; i_p0_we = 1'b0; i_p0_addr = 24'h000200;
        i_p1_req = 1'b1; i_p1_we = 1'b0; i_p1_addr = 24'h000300;
        run_until(8, 200);
        i_p0_req = 1'b0; i_p1_req = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        scnt = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef PSRAM_ARB_STARVE_EN
            if (scnt == 3) begin exp_port = 1; scnt = 0; end
            else begin exp_port = 0; scnt++; end
`else
            exp_port = 0;
`endif
            got = (i < order_q.size()) ? order_q[i] : -1;
            check("starve_order", 80'(got), 80'(exp_port));
        end
        repeat (8) tick();

        // reset while waiting on the controller
        clear_log(); bd = 1; dd = 10;
        i_p1_req = 1'b1; i_p1_we = 1'b0; i_p1_addr = 24'h000123;
        repeat (4) tick();
        check("in_wait", 80'({o_mem_stb, o_grant}), 80'(3'b010));
        i_rstn = 1'b0;
        tick(); tick();
        check("wait_rst_outputs", outs(), 80'd0);
        i_rstn = 1'b1;
        repeat (15) tick();
        check("wait_rst_no_done", 80'(n_done0 + n_done1), 80'd0);
        clear_log(); bd = 2; dd = 3;
        i_p0_req = 1'b1; i_p0_we = 1'b0; i_p0_addr = 24'h000123;
        run_until(1, 40);
        tick();
        check("post_rst_dout", 80'(dout0_v), 80'h8765);
        check("post_rst_done", 80'({n_done0[3:0], n_done1[3:0]}), 80'h10);

        // random traffic against the reference memory
        for (int it = 0; it < 30; it++) begin
            r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r1 = 1'b1;
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a0 = 24'h000100 + 24'($urandom_range(0, 7));
            a1 = 24'h000100 + 24'($urandom_range(0, 7));
            d0 = 16'($urandom); d1 = 16'($urandom);
            bd = int'($urandom_range(1, 3)); dd = int'($urandom_range(1, 4));
            nob = ($urandom_range(0, 3) == 0);
            e0 = 16'h0; e1 = 16'h0;
            if (r0) begin
                if (w0) ref_mem[a0] = d0; else e0 = ref_rd(a0);
            end
            if (r1) begin
                if (w1) ref_mem[a1] = d1; else e1 = ref_rd(a1);
            end
            clear_log();
            if (r0) begin i_p0_req = 1'b1; i_p0_we = w0; i_p0_addr = a0; i_p0_din = d0; end
            if (r1) begin i_p1_req = 1'b1; i_p1_we = w1; i_p1_addr = a1; i_p1_din = d1; end
            run_until(int'(r0) + int'(r1), 60);
            tick(); tick();
            check("rnd_done0", 80'(n_done0), 80'(r0));
            check("rnd_done1", 80'(n_done1), 80'(r1));
            if (r0 && !w0) check("rnd_dout0", 80'(dout0_v), 80'(e0));
            if (r1 && !w1) check("rnd_dout1", 80'(dout1_v), 80'(e1));
            if (r0 && r1) check("rnd_b2b", 80'(ack1_cyc), 80'(done0_cyc + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
